// File: rtl/fault_inject_sched.sv
// Fault-injection scheduler: waits a programmed interval, strobes the mask LFSR,
// captures the new mask and hands it to the target over valid/ready, burst_len times.
module fault_inject_sched #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned PERIOD_W = 16,
    parameter int unsigned BURST_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic [PERIOD_W-1:0] period,
    input  logic [BURST_W-1:0]  burst_len,
    input  logic [WIDTH-1:0]    lfsr_mask,
    output logic                lfsr_enable,
    output logic                inject_valid,
    input  logic                inject_ready,
    output logic [WIDTH-1:0]    inject_mask,
    output logic                busy,
    output logic                done,
    output logic [BURST_W-1:0]  inject_count
);

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StAdvance,
        StCapture,
        StInject,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] wait_q, wait_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [BURST_W-1:0]  remaining_q, remaining_d;
    logic [BURST_W-1:0]  count_q, count_d;
    logic [WIDTH-1:0]    mask_q, mask_d;
    logic                xfer;

    assign xfer = (state_q == StInject) && inject_ready;

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        period_d    = period_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        mask_d      = mask_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    // A zero period is run as a one-cycle wait.
                    period_d    = (period == '0) ? PERIOD_W'(1) : period;
                    wait_d      = (period == '0) ? '0 : period - PERIOD_W'(1);
                    remaining_d = burst_len;
                    count_d     = '0;
                    state_d     = (burst_len == '0) ? StDone : StWait;
                end
            end
            StWait: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (wait_q == '0) begin
                    state_d = StAdvance;
                end else begin
                    wait_d = wait_q - PERIOD_W'(1);
                end
            end
            StAdvance: begin
                state_d = stop ? StIdle : StCapture;
            end
            StCapture: begin
                if (stop) begin
                    state_d = StIdle;
                end else begin
                    mask_d = lfsr_mask;
                    // An all-zero mask is useless as a fault; advance again immediately.
                    state_d = (lfsr_mask == '0) ? StAdvance : StInject;
                end
            end
            StInject: begin
                if (xfer) begin
                    if (count_q != '1) begin
                        count_d = count_q + BURST_W'(1);
                    end
                    remaining_d = remaining_q - BURST_W'(1);
                end
                if (stop) begin
                    state_d = StIdle;
                end else if (xfer) begin
                    if (remaining_q == BURST_W'(1)) begin
                        state_d = StDone;
                    end else begin
                        state_d = StWait;
                        wait_d  = period_q - PERIOD_W'(1);
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            wait_q      <= '0;
            period_q    <= '0;
            remaining_q <= '0;
            count_q     <= '0;
            mask_q      <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            period_q    <= period_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            mask_q      <= mask_d;
        end
    end

    assign lfsr_enable  = (state_q == StAdvance);
    assign inject_valid = (state_q == StInject);
    assign busy         = (state_q != StIdle);
    assign done         = (state_q == StDone);
    assign inject_mask  = mask_q;
    assign inject_count = count_q;

endmodule

// File: tb/tb_fault_inject_sched.sv
// Directed bench for fault_inject_sched: burst timing, backpressure, zero masks,
// degenerate fields, abort and asynchronous reset.
module tb_fault_inject_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop;
    logic [15:0] period;
    logic [7:0]  burst_len;
    logic [31:0] lfsr_mask;
    logic        lfsr_enable, inject_valid, inject_ready;
    logic [31:0] inject_mask;
    logic        busy, done;
    logic [7:0]  inject_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int en_q[$];
    int n;
    int d0;

    fault_inject_sched dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .period       (period),
        .burst_len    (burst_len),
        .lfsr_mask    (lfsr_mask),
        .lfsr_enable  (lfsr_enable),
        .inject_valid (inject_valid),
        .inject_ready (inject_ready),
        .inject_mask  (inject_mask),
        .busy         (busy),
        .done         (done),
        .inject_count (inject_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (lfsr_enable) en_q.push_back(cyc);
        if (done) done_cnt <= done_cnt + 1;
        cyc <= cyc + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(output int cnt);
        cnt = 0;
        while (!inject_valid && cnt < 200) begin
            tick();
            cnt++;
        end
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        while (!done && cnt < 200) begin
            tick();
            cnt++;
        end
    endtask

    task automatic go(input logic [15:0] p, input logic [7:0] b);
        period    = p;
        burst_len = b;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0; period = '0; burst_len = '0;
        lfsr_mask = '0; inject_ready = 1'b0;
        #1;
        chk("rst_valid", {31'b0, inject_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_mask", inject_mask, 32'd0);
        chk("rst_count", {24'b0, inject_count}, 32'd0);
        #20;
        rst = 1'b1;
        tick();

        // Basic burst
        en_q.delete();
        d0 = done_cnt;
        inject_ready = 1'b1;
        lfsr_mask    = 32'h1234_5678;
        go(16'd4, 8'd3);
        wait_valid(n);
        chk("basic_first_valid_lat", n, 32'd6);
        chk("basic_mask", inject_mask, 32'h1234_5678);
        wait_done(n);
        chk("basic_done", {31'b0, done}, 32'd1);
        chk("basic_count", {24'b0, inject_count}, 32'd3);
        chk("basic_busy_in_done", {31'b0, busy}, 32'd1);
        tick();
        chk("basic_busy_after", {31'b0, busy}, 32'd0);
        chk("basic_done_pulses", done_cnt - d0, 32'd1);
        chk("basic_en_pulses", en_q.size(), 32'd3);
        // Per injection: 4 WAIT + ADVANCE + CAPTURE + 1 INJECT cycle.
        if (en_q.size() == 3) begin
            chk("basic_en_gap1", en_q[1] - en_q[0], 32'd7);
            chk("basic_en_gap2", en_q[2] - en_q[1], 32'd7);
        end

        // Backpressure
        en_q.delete();
        inject_ready = 1'b0;
        lfsr_mask    = 32'hA5A5_0001;
        go(16'd2, 8'd1);
        wait_valid(n);
        chk("bp_first_valid_lat", n, 32'd4);
        lfsr_mask = 32'h0BAD_0BAD;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid_hold", {31'b0, inject_valid}, 32'd1);
            chk("bp_mask_hold", inject_mask, 32'hA5A5_0001);
        end
        chk("bp_en_pulses", en_q.size(), 32'd1);
        inject_ready = 1'b1;
        tick();
        chk("bp_done", {31'b0, done}, 32'd1);
        chk("bp_count", {24'b0, inject_count}, 32'd1);
        tick();

        // Zero mask on first capture
        en_q.delete();
        lfsr_mask = 32'h0;
        go(16'd1, 8'd1);
        tick();
        tick();
        tick();
        chk("zero_readvance", {31'b0, lfsr_enable}, 32'd1);
        lfsr_mask = 32'hDEAD_BEEF;
        tick();
        tick();
        chk("zero_valid", {31'b0, inject_valid}, 32'd1);
        chk("zero_mask", inject_mask, 32'hDEAD_BEEF);
        chk("zero_en_pulses", en_q.size(), 32'd2);
        if (en_q.size() == 2) chk("zero_en_gap", en_q[1] - en_q[0], 32'd2);
        tick();
        chk("zero_done", {31'b0, done}, 32'd1);
        chk("zero_count", {24'b0, inject_count}, 32'd1);
        tick();

        // Degenerate fields
        en_q.delete();
        go(16'd5, 8'd0);
        chk("deg_bl0_done", {31'b0, done}, 32'd1);
        chk("deg_bl0_count", {24'b0, inject_count}, 32'd0);
        tick();
        chk("deg_bl0_idle", {31'b0, busy}, 32'd0);
        chk("deg_bl0_no_en", en_q.size(), 32'd0);
        lfsr_mask = 32'h0000_0F0F;
        go(16'd0, 8'd1);
        wait_valid(n);
        chk("deg_p0_lat", n, 32'd3);
        tick();
        chk("deg_p0_done", {31'b0, done}, 32'd1);
        tick();

        // Abort mid-WAIT of the second injection
        d0 = done_cnt;
        lfsr_mask = 32'h1111_1111;
        go(16'd3, 8'd4);
        wait_valid(n);
        chk("abort_lat", n, 32'd5);
        tick();
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("abort_idle", {31'b0, busy}, 32'd0);
        chk("abort_count", {24'b0, inject_count}, 32'd1);
        tick();
        tick();
        chk("abort_no_done", done_cnt - d0, 32'd0);

        // Stop coincident with a transfer
        d0 = done_cnt;
        go(16'd1, 8'd4);
        wait_valid(n);
        tick();
        inject_ready = 1'b0;
        wait_valid(n);
        chk("stopx_relat", n, 32'd3);
        inject_ready = 1'b1;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stopx_idle", {31'b0, busy}, 32'd0);
        chk("stopx_count", {24'b0, inject_count}, 32'd2);
        tick();
        chk("stopx_no_done", done_cnt - d0, 32'd0);

        // Asynchronous reset mid-INJECT
        inject_ready = 1'b0;
        lfsr_mask    = 32'hCAFE_F00D;
        go(16'd2, 8'd2);
        wait_valid(n);
        chk("arst_pre_valid", {31'b0, inject_valid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", {31'b0, inject_valid}, 32'd0);
        chk("arst_mask", inject_mask, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_en", {31'b0, lfsr_enable}, 32'd0);
        chk("arst_count", {24'b0, inject_count}, 32'd0);
        chk("arst_done", {31'b0, done}, 32'd0);
        rst = 1'b1;
        tick();
        inject_ready = 1'b1;
        go(16'd1, 8'd1);
        wait_done(n);
        chk("arst_after_done", {31'b0, done}, 32'd1);
        chk("arst_after_count", {24'b0, inject_count}, 32'd1);
        chk("arst_after_mask", inject_mask, 32'hCAFE_F00D);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
